// File: rtl/seq_detect_moore.sv
// Runtime-configurable serial pattern detector with a registered one-cycle detect pulse.
// Matching compares a shifting bit history against the stored pattern, so overlap and arbitrary patterns are exact.
module seq_detect_moore #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ip,
  input  logic               ip_valid,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               op,
  output logic [CNT_W-1:0]   det_count,
  output logic [LEN_W-1:0]   cur_len
);

  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(4'b1100);
  localparam logic [LEN_W-1:0]   DEF_LEN   = LEN_W'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > MAX_LEN_L) ? MAX_LEN_L : l;
  endfunction

  // Selects the low l bits, i.e. the most recent l received bits of the history.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  logic [MAX_LEN-1:0] pat_r, pat_nx;
  logic [LEN_W-1:0]   len_r, len_nx;
  logic [MAX_LEN-1:0] hist, hist_nx;
  logic [LEN_W-1:0]   fill, fill_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               op_nx;
  logic [MAX_LEN-1:0] nh, mask;
  logic [LEN_W-1:0]   nf;
  logic               match;

  always_comb begin
    pat_nx  = pat_r;
    len_nx  = len_r;
    hist_nx = hist;
    fill_nx = fill;
    cnt_nx  = det_count;
    op_nx   = 1'b0;
    nh      = {hist[MAX_LEN-2:0], ip};
    nf      = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
    mask    = len_mask(len_r);
    match   = (len_r != '0) && (nf >= len_r) && ((nh & mask) == (pat_r & mask));
    if (cfg_load) begin
      pat_nx  = cfg_pattern;
      len_nx  = clamp_len(cfg_len);
      hist_nx = '0;
      fill_nx = '0;
    end else if (ip_valid) begin
      hist_nx = nh;
      fill_nx = nf;
      if (match) begin
        op_nx  = 1'b1;
        cnt_nx = sat_inc(det_count);
        // Non-overlap: the matched window must not seed the next match.
        if (!overlap) begin
          hist_nx = '0;
          fill_nx = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r     <= DEF_PAT;
      len_r     <= DEF_LEN;
      hist      <= '0;
      fill      <= '0;
      op        <= 1'b0;
      det_count <= '0;
    end else begin
      pat_r     <= pat_nx;
      len_r     <= len_nx;
      hist      <= hist_nx;
      fill      <= fill_nx;
      op        <= op_nx;
      det_count <= cnt_nx;
    end
  end

  assign cur_len = len_r;

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed bench for seq_detect_moore: one task per scenario, expected values hand-computed.
module tb_seq_detect_moore;

  logic       clk = 1'b0;
  logic       reset, ip, ip_valid, overlap, cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       op, op2;
  logic [7:0] det_count;
  logic [1:0] det_count2;
  logic [3:0] cur_len, cur_len2;
  int tests_run = 0;
  int failures  = 0;

  seq_detect_moore #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .op(op), .det_count(det_count), .cur_len(cur_len)
  );

  seq_detect_moore #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .ip(ip), .ip_valid(ip_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .op(op2), .det_count(det_count2), .cur_len(cur_len2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    ip = b;
    ip_valid = 1'b1;
    tick();
    ip_valid = 1'b0;
    ip = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // A valid 1 is presented during the load; it must be ignored.
  task automatic load(input logic [7:0] p, input logic [3:0] l);
    cfg_pattern = p;
    cfg_len = l;
    cfg_load = 1'b1;
    ip = 1'b1;
    ip_valid = 1'b1;
    tick();
    cfg_load = 1'b0;
    ip_valid = 1'b0;
    ip = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (op !== 1'b0) begin failures++; $display("FAIL reset_op got %0b want 0", op); end
    tests_run++;
    if (det_count !== 8'd0) begin failures++; $display("FAIL reset_count got %0d want 0", det_count); end
    tests_run++;
    if (cur_len !== 4'd4) begin failures++; $display("FAIL reset_len got %0d want 4", cur_len); end
  endtask

  task automatic test_default();
    logic [8:0] bits = 9'b011001100;
    logic [8:0] exp  = 9'b000010001;
    overlap = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== exp[i]) begin failures++; $display("FAIL default_op sample %0d got %0b want %0b", 9 - i, op, exp[i]); end
    end
    tests_run++;
    if (det_count !== 8'd2) begin failures++; $display("FAIL default_count got %0d want 2", det_count); end
  endtask

  task automatic test_pattern_101();
    logic [4:0] bits  = 5'b10101;
    logic [4:0] exp_o = 5'b00101;
    logic [4:0] exp_n = 5'b00100;
    load(8'b101, 4'd3);
    tests_run++;
    if (cur_len !== 4'd3) begin failures++; $display("FAIL load_len got %0d want 3", cur_len); end
    overlap = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== exp_o[i]) begin failures++; $display("FAIL ovl_op sample %0d got %0b want %0b", 5 - i, op, exp_o[i]); end
    end
    tests_run++;
    if (det_count !== 8'd4) begin failures++; $display("FAIL ovl_count got %0d want 4", det_count); end
    load(8'b101, 4'd3);
    overlap = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== exp_n[i]) begin failures++; $display("FAIL novl_op sample %0d got %0b want %0b", 5 - i, op, exp_n[i]); end
    end
    tests_run++;
    if (det_count !== 8'd5) begin failures++; $display("FAIL novl_count got %0d want 5", det_count); end
  endtask

  task automatic test_valid_gaps();
    logic [3:0] bits = 4'b1100;
    logic [3:0] exp  = 4'b0001;
    do_reset();
    overlap = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== exp[i]) begin failures++; $display("FAIL gap_op sample %0d got %0b want %0b", 4 - i, op, exp[i]); end
      for (int g = 0; g < 3; g++) begin
        tick();
        tests_run++;
        if (op !== 1'b0) begin failures++; $display("FAIL gap_idle_op got %0b want 0", op); end
      end
    end
    tests_run++;
    if (det_count !== 8'd1) begin failures++; $display("FAIL gap_count got %0d want 1", det_count); end
  endtask

  task automatic test_load_mid_sequence();
    logic [5:0] bits = 6'b001100;
    logic [5:0] exp  = 6'b000001;
    do_reset();
    overlap = 1'b0;
    send(1'b1);
    send(1'b1);
    load(8'b1100, 4'd4);
    for (int i = 5; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== exp[i]) begin failures++; $display("FAIL midload_op sample %0d got %0b want %0b", 6 - i, op, exp[i]); end
    end
    tests_run++;
    if (det_count !== 8'd1) begin failures++; $display("FAIL midload_count got %0d want 1", det_count); end
  endtask

  task automatic test_len_zero();
    logic [7:0] bits = 8'b00110100;
    overlap = 1'b1;
    load(8'h00, 4'd0);
    tests_run++;
    if (cur_len !== 4'd0) begin failures++; $display("FAIL len0_len got %0d want 0", cur_len); end
    for (int i = 7; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== 1'b0) begin failures++; $display("FAIL len0_op sample %0d got %0b want 0", 8 - i, op); end
    end
    tests_run++;
    if (det_count !== 8'd1) begin failures++; $display("FAIL len0_count got %0d want 1", det_count); end
  endtask

  task automatic test_len_clamp();
    logic [7:0] bits = 8'b10110011;
    logic [7:0] exp  = 8'b00000001;
    overlap = 1'b0;
    load(8'b10110011, 4'd11);
    tests_run++;
    if (cur_len !== 4'd8) begin failures++; $display("FAIL clamp_len got %0d want 8", cur_len); end
    for (int i = 7; i >= 0; i--) begin
      send(bits[i]);
      tests_run++;
      if (op !== exp[i]) begin failures++; $display("FAIL clamp_op sample %0d got %0b want %0b", 8 - i, op, exp[i]); end
    end
    tests_run++;
    if (det_count !== 8'd2) begin failures++; $display("FAIL clamp_count got %0d want 2", det_count); end
  endtask

  task automatic test_back_to_back_saturation();
    do_reset();
    overlap = 1'b1;
    load(8'b11, 4'd2);
    for (int i = 0; i < 8; i++) begin
      send(1'b1);
      tests_run++;
      if (op !== (i != 0)) begin failures++; $display("FAIL b2b_op sample %0d got %0b want %0b", i + 1, op, (i != 0)); end
    end
    tests_run++;
    if (det_count2 !== 2'd3) begin failures++; $display("FAIL sat_count got %0d want 3", det_count2); end
    tests_run++;
    if (det_count !== 8'd7) begin failures++; $display("FAIL wide_count got %0d want 7", det_count); end
    // Reset while a valid 1 is presented mid-stream.
    ip = 1'b1;
    ip_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ip_valid = 1'b0;
    tests_run++;
    if (op !== 1'b0 || op2 !== 1'b0) begin failures++; $display("FAIL midreset_op got %0b/%0b want 0/0", op, op2); end
    tests_run++;
    if (det_count !== 8'd0 || det_count2 !== 2'd0) begin failures++; $display("FAIL midreset_count got %0d/%0d want 0/0", det_count, det_count2); end
    tests_run++;
    if (cur_len !== 4'd4 || cur_len2 !== 4'd4) begin failures++; $display("FAIL midreset_len got %0d/%0d want 4/4", cur_len, cur_len2); end
  endtask

  initial begin
    reset = 1'b0;
    ip = 1'b0;
    ip_valid = 1'b0;
    overlap = 1'b0;
    cfg_load = 1'b0;
    cfg_pattern = '0;
    cfg_len = '0;
    test_reset();
    test_default();
    test_pattern_101();
    test_valid_gaps();
    test_load_mid_sequence();
    test_len_zero();
    test_len_clamp();
    test_back_to_back_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
